mem_wb_stage: RTL and testbench

Memory-access stage of the five-stage RISC-V pipeline, consuming the EX/MEM register outputs. It owns the word-organised data memory, performs word and byte stores and word and signed-halfword loads, and resolves the branch decision. Its results are registered into the MEM/WB boundary, which drives the register-file write port in writeback.

---
 rtl/mem_wb_stage.sv | 97 +++++++++
 tb/tb_mem_wb_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage of the five-stage RISC-V pipeline.
// Owns the word-organised data memory, performs word/byte stores and
// word/signed-halfword loads, decodes the branch decision, and registers
// its results into the MEM/WB boundary that feeds writeback.
module mem_wb_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regWrite_in,
    input  logic        memtoReg_in,
    input  logic        memWrite_in,
    input  logic        sb_in,
    input  logic        lh_in,
    input  logic        zeroFlag_in,
    input  logic [1:0]  branch_in,
    input  logic [31:0] readData2_in,
    input  logic [31:0] ALUresult_in,
    input  logic [4:0]  rd_in,
    output logic        pcSrc,
    output logic        regWrite,
    output logic [4:0]  rd,
    output logic [31:0] writeData,
    output logic [31:0] ALUresult
);

    // Word-organised data memory; contents survive reset.
    logic [31:0] mem [DEPTH];

    logic [ADDR_W-1:0] wordIndex;
    logic [1:0]        byteLane;
    logic [31:0]       readWord;
    logic [15:0]       halfWord;
    logic [31:0]       loadData;
    logic [31:0]       nextWriteData;

    // Upper address bits are dropped so the memory wraps modulo DEPTH words.
    assign wordIndex = ALUresult_in[ADDR_W+1:2];
    assign byteLane  = ALUresult_in[1:0];

    // Reads see the memory as it stands before this edge's store commits,
    // which is what makes an illegal load+store return the pre-store word.
    assign readWord = mem[wordIndex];
    assign halfWord = ALUresult_in[1] ? readWord[31:16] : readWord[15:0];

    // Pick the loaded value (word or sign-extended half) and the writeback source.
    always_comb begin
        loadData      = readWord;
        nextWriteData = ALUresult_in;
        if (lh_in) begin
            loadData = {{16{halfWord[15]}}, halfWord};
        end
        if (memtoReg_in) begin
            nextWriteData = loadData;
        end
    end

    // Branch/jump decision is combinational so fetch can redirect this cycle.
    always_comb begin
        pcSrc = 1'b0;
        case (branch_in)
            2'b00: pcSrc = 1'b0;
            2'b01: pcSrc = zeroFlag_in;
            2'b10: pcSrc = ~zeroFlag_in;
            2'b11: pcSrc = 1'b1;
            default: pcSrc = 1'b0;
        endcase
    end

    // Commit stores; a store seen while reset is held low is discarded.
    always_ff @(posedge clk) begin
        if (reset && memWrite_in) begin
            if (sb_in) begin
                mem[wordIndex][{byteLane, 3'b000} +: 8] <= readData2_in[7:0];
            end else begin
                mem[wordIndex] <= readData2_in;
            end
        end
    end

    // MEM/WB pipeline register; writes to x0 are suppressed here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regWrite  <= 1'b0;
            rd        <= 5'd0;
            writeData <= 32'd0;
            ALUresult <= 32'd0;
        end else begin
            regWrite  <= regWrite_in & (rd_in != 5'd0);
            rd        <= rd_in;
            writeData <= nextWriteData;
            ALUresult <= ALUresult_in;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage. Expected MEM/WB values
// come from a byte-addressed memory model and are queued when each
// instruction is issued; a monitor pops and compares after every edge.
module tb_mem_wb_stage;

    logic        clk;
    logic        reset;
    logic        regWrite_in;
    logic        memtoReg_in;
    logic        memWrite_in;
    logic        sb_in;
    logic        lh_in;
    logic        zeroFlag_in;
    logic [1:0]  branch_in;
    logic [31:0] readData2_in;
    logic [31:0] ALUresult_in;
    logic [4:0]  rd_in;
    logic        pcSrc;
    logic        regWrite;
    logic [4:0]  rd;
    logic [31:0] writeData;
    logic [31:0] ALUresult;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [31:0] alu;
    } outT;

    outT expQ[$];
    logic [7:0] modelMem [1024];
    int  compared = 0;
    int  mismatched = 0;
    bit  monitorOn = 0;

    mem_wb_stage #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .regWrite_in(regWrite_in),
        .memtoReg_in(memtoReg_in),
        .memWrite_in(memWrite_in),
        .sb_in(sb_in),
        .lh_in(lh_in),
        .zeroFlag_in(zeroFlag_in),
        .branch_in(branch_in),
        .readData2_in(readData2_in),
        .ALUresult_in(ALUresult_in),
        .rd_in(rd_in),
        .pcSrc(pcSrc),
        .regWrite(regWrite),
        .rd(rd),
        .writeData(writeData),
        .ALUresult(ALUresult)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports any miss.
    task automatic checkOutput(input string name, input logic [69:0] act, input logic [69:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] modelWord(input logic [31:0] addr);
        int b;
        b = int'({addr[9:2], 2'b00});
        return {modelMem[b+3], modelMem[b+2], modelMem[b+1], modelMem[b]};
    endfunction

    function automatic logic [31:0] modelHalf(input logic [31:0] addr);
        int b;
        logic signed [15:0] h;
        b = int'({addr[9:2], 2'b00}) + (addr[1] ? 2 : 0);
        h = {modelMem[b+1], modelMem[b]};
        return 32'($signed(h));
    endfunction

    // Drive one instruction for one cycle, queue its MEM/WB result, update the model.
    task automatic applyStimulus(input logic rw, input logic mtr, input logic mw,
                                 input logic sb, input logic lh, input logic zf,
                                 input logic [1:0] br, input logic [31:0] d2,
                                 input logic [31:0] alu, input logic [4:0] rdv);
        outT e;
        logic expPc;
        int b;
        @(negedge clk);
        regWrite_in  = rw;
        memtoReg_in  = mtr;
        memWrite_in  = mw;
        sb_in        = sb;
        lh_in        = lh;
        zeroFlag_in  = zf;
        branch_in    = br;
        readData2_in = d2;
        ALUresult_in = alu;
        rd_in        = rdv;
        e.rw  = rw && (rdv != 0);
        e.rd  = rdv;
        e.alu = alu;
        if (mtr) e.wd = lh ? modelHalf(alu) : modelWord(alu);
        else     e.wd = alu;
        expQ.push_back(e);
        if (mw) begin
            b = int'(alu[9:0]);
            if (sb) modelMem[b] = d2[7:0];
            else begin
                b = int'({alu[9:2], 2'b00});
                for (int k = 0; k < 4; k++) modelMem[b+k] = d2[8*k +: 8];
            end
        end
        expPc = (br == 2'b11) || (br == 2'b01 && zf) || (br == 2'b10 && !zf);
        #1;
        checkOutput("pcSrc", {69'd0, pcSrc}, {69'd0, expPc});
    endtask

    task automatic driveBubble();
        regWrite_in = 0; memtoReg_in = 0; memWrite_in = 0; sb_in = 0; lh_in = 0;
        zeroFlag_in = 0; branch_in = 0; readData2_in = 0; ALUresult_in = 0; rd_in = 0;
    endtask

    // Monitor: after each edge, compare the registered outputs with the oldest expectation.
    initial begin
        outT e;
        forever begin
            @(posedge clk);
            #1;
            if (monitorOn && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("memwb", {regWrite, rd, writeData, ALUresult}, e);
            end
        end
    end

    task automatic drainQueue();
        int n;
        n = 0;
        while (expQ.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        if (expQ.size() > 0) begin
            checkOutput("drainTimeout", 70'(expQ.size()), 70'd0);
            expQ.delete();
        end
    endtask

    initial begin
        logic mtr, mw;
        logic [31:0] addr;
        driveBubble();
        reset = 1'b0;
        for (int i = 0; i < 1024; i++) modelMem[i] = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetState", {regWrite, rd, writeData, ALUresult}, 70'd0);
        @(negedge clk);
        reset = 1'b1;
        monitorOn = 1;

        // Clear every memory word so nothing relies on power-up contents.
        for (int i = 0; i < 256; i++)
            applyStimulus(0, 0, 1, 0, 0, 0, 2'b00, 32'd0, 32'(i * 4), 5'd0);

        // Word store then load.
        applyStimulus(0, 0, 1, 0, 0, 0, 2'b00, 32'hDEADBEEF, 32'h10, 5'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 2'b00, 32'd0, 32'h10, 5'd5);

        // Byte store then word/halfword loads.
        applyStimulus(0, 0, 1, 0, 0, 0, 2'b00, 32'h00000000, 32'h20, 5'd0);
        applyStimulus(0, 0, 1, 1, 0, 0, 2'b00, 32'h123456A5, 32'h23, 5'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 2'b00, 32'd0, 32'h20, 5'd6);
        applyStimulus(1, 1, 0, 0, 1, 0, 2'b00, 32'd0, 32'h22, 5'd7);
        applyStimulus(1, 1, 0, 0, 1, 0, 2'b00, 32'd0, 32'h20, 5'd8);
        applyStimulus(1, 1, 0, 0, 1, 0, 2'b00, 32'd0, 32'h23, 5'd9);

        // Branch decode, every code with both flag values.
        for (int br = 0; br < 4; br++)
            for (int zf = 0; zf < 2; zf++)
                applyStimulus(1, 0, 0, 0, 0, 1'(zf), 2'(br), 32'd0, 32'(br * 2 + zf), 5'd3);

        // Address wrap and x0 suppression.
        applyStimulus(0, 0, 1, 0, 0, 0, 2'b00, 32'h12345678, 32'h400, 5'd0);
        applyStimulus(1, 1, 0, 0, 0, 0, 2'b00, 32'd0, 32'h000, 5'd10);
        applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, 32'd0, 32'd7, 5'd0);

        // Randomised traffic confined to a few words so stores and loads collide.
        for (int i = 0; i < 400; i++) begin
            mw   = ($urandom_range(0, 2) == 0);
            mtr  = ($urandom_range(0, 1) == 1);
            if (mw && mtr && $urandom_range(0, 9) != 0) mtr = 0;
            addr = {$urandom_range(0, 8'hFF), 2'b00, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            applyStimulus(1'($urandom_range(0, 1)), mtr, mw, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), $urandom, addr, 5'($urandom_range(0, 31)));
        end
        drainQueue();

        // Asynchronous reset mid-operation with a store pending at address 0x10.
        monitorOn = 0;
        regWrite_in = 1; rd_in = 5'd4; ALUresult_in = 32'h10;
        memWrite_in = 1; sb_in = 0; readData2_in = 32'hCAFEF00D;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("asyncReset", {regWrite, rd, writeData, ALUresult}, 70'd0);
        @(posedge clk);
        #1;
        checkOutput("resetHeld", {regWrite, rd, writeData, ALUresult}, 70'd0);
        @(negedge clk);
        driveBubble();
        reset = 1'b1;
        monitorOn = 1;
        // Model: the store present at the edge before reset did commit (reset was high then).
        for (int k = 0; k < 4; k++) modelMem[16+k] = 8'(32'hCAFEF00D >> (8 * k));
        applyStimulus(1, 1, 0, 0, 0, 0, 2'b00, 32'd0, 32'h10, 5'd11);
        drainQueue();

        // A store held only while reset is low must not reach memory.
        monitorOn = 0;
        reset = 1'b0;
        memWrite_in = 1; sb_in = 0; ALUresult_in = 32'h10; readData2_in = 32'h0BADF00D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        driveBubble();
        reset = 1'b1;
        monitorOn = 1;
        applyStimulus(1, 1, 0, 0, 0, 0, 2'b00, 32'd0, 32'h10, 5'd12);
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 32'd0, 32'd0, 5'd0);
        drainQueue();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
